// File: rtl/sccb_arbiter.sv
// Two-port round-robin arbiter in front of a single SCCB_interface master.
// Owns the start/ready handshake, the start-acknowledge timeout and the post-transaction guard gap.
module sccb_arbiter #(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int BUSY_TIMEOUT = 256,
  parameter int GAP_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_accept,
  output logic       req0_done,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_accept,
  output logic       req1_done,
  output logic       req1_err,
  input  logic       sccb_ready,
  output logic       sccb_start,
  output logic [7:0] sccb_addr,
  output logic [7:0] sccb_data,
  output logic       grant_id,
  output logic       busy
);

  localparam int MAX_CNT = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  // CLK_FREQ only documents how the cycle counts were derived; a non-positive value widens nothing useful.
  localparam int TW = $clog2(MAX_CNT + 1) + ((CLK_FREQ > 0) ? 0 : 1);
  localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_q, last_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic          grant_q, grant_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          acc0_q, acc0_d, acc1_q, acc1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic          win1;
  state_t        after_txn;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    last_d    = last_q;
    addr_d    = addr_q;
    data_d    = data_q;
    grant_d   = grant_q;
    start_d   = 1'b0;
    acc0_d    = 1'b0;
    acc1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    after_txn = (GAP_CYCLES == 0) ? IDLE : GAP;
    // Port 1 wins when it is alone, or on a tie when port 0 had the previous grant.
    win1      = req1_valid && (!req0_valid || !last_q);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (sccb_ready && (req0_valid || req1_valid)) begin
          state_d = ISSUE;
          grant_d = win1;
          last_d  = win1;
          addr_d  = win1 ? req1_addr : req0_addr;
          data_d  = win1 ? req1_data : req0_data;
          acc0_d  = !win1;
          acc1_d  = win1;
          start_d = 1'b1;
        end
      end
      ISSUE: begin
        if (!sccb_ready) begin
          state_d = WAIT_DONE;
          timer_d = '0;
        end else if (timer_q == BUSY_LAST) begin
          state_d = after_txn;
          timer_d = '0;
          err0_d  = !grant_q;
          err1_d  = grant_q;
        end else begin
          start_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_q;
        if (sccb_ready) begin
          state_d = after_txn;
          timer_d = '0;
          done0_d = !grant_q;
          done1_d = grant_q;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      acc0_q  <= 1'b0;
      acc1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  assign req0_accept = acc0_q;
  assign req1_accept = acc1_q;
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign req0_err    = err0_q;
  assign req1_err    = err1_q;
  assign sccb_start  = start_q;
  assign sccb_addr   = addr_q;
  assign sccb_data   = data_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed self-checking bench for sccb_arbiter: default build plus a GAP_CYCLES=0 build.
module tb_sccb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_addr = '0, req0_data = '0, req1_addr = '0, req1_data = '0;
  logic       req0_accept, req0_done, req0_err, req1_accept, req1_done, req1_err;
  logic       sccb_ready = 1'b1;
  logic       sccb_start, grant_id, busy;
  logic [7:0] sccb_addr, sccb_data;

  logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic [7:0] b_req0_addr = '0, b_req0_data = '0, b_req1_addr = '0, b_req1_data = '0;
  logic       b_req0_accept, b_req0_done, b_req0_err, b_req1_accept, b_req1_done, b_req1_err;
  logic       b_sccb_ready = 1'b1;
  logic       b_sccb_start, b_grant_id, b_busy;
  logic [7:0] b_sccb_addr, b_sccb_data;

  int checks = 0;
  int errors = 0;
  int n_acc0 = 0, n_acc1 = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0, n_start = 0;

  always #5 clk = ~clk;

  sccb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_accept(req0_accept), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_accept(req1_accept), .req1_done(req1_done), .req1_err(req1_err),
    .sccb_ready(sccb_ready), .sccb_start(sccb_start), .sccb_addr(sccb_addr),
    .sccb_data(sccb_data), .grant_id(grant_id), .busy(busy)
  );

  sccb_arbiter #(.GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_data(b_req0_data),
    .req0_accept(b_req0_accept), .req0_done(b_req0_done), .req0_err(b_req0_err),
    .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_data(b_req1_data),
    .req1_accept(b_req1_accept), .req1_done(b_req1_done), .req1_err(b_req1_err),
    .sccb_ready(b_sccb_ready), .sccb_start(b_sccb_start), .sccb_addr(b_sccb_addr),
    .sccb_data(b_sccb_data), .grant_id(b_grant_id), .busy(b_busy)
  );

  // Advance one clock and sample just after the edge, tallying pulses of the main instance.
  task automatic tick();
    @(posedge clk);
    #1;
    if (req0_accept) n_acc0++;
    if (req1_accept) n_acc1++;
    if (req0_done)   n_done0++;
    if (req1_done)   n_done1++;
    if (req0_err)    n_err0++;
    if (req1_err)    n_err1++;
    if (sccb_start)  n_start++;
  endtask

  // Wait for a grant, check it, act as an SCCB master that goes busy at once, then wait for idle.
  task automatic serve(input logic drop, input logic exp_gid, input logic [7:0] exp_addr,
                       input logic [7:0] exp_data);
    logic seen;
    int   errs_before;
    errs_before = n_err0 + n_err1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (sccb_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL serve_start actual=no start required=start within 100 cycles");
      return;
    end
    checks++;
    if (grant_id !== exp_gid) begin
      errors++;
      $display("[TB] FAIL serve_grant actual=%0b required=%0b", grant_id, exp_gid);
    end
    checks++;
    if ({req1_accept, req0_accept} !== (exp_gid ? 2'b10 : 2'b01)) begin
      errors++;
      $display("[TB] FAIL serve_accept actual=%b required=%b", {req1_accept, req0_accept},
               exp_gid ? 2'b10 : 2'b01);
    end
    checks++;
    if ({sccb_addr, sccb_data} !== {exp_addr, exp_data}) begin
      errors++;
      $display("[TB] FAIL serve_addr_data actual=%h required=%h", {sccb_addr, sccb_data},
               {exp_addr, exp_data});
    end
    if (drop) begin
      if (exp_gid) req1_valid = 1'b0;
      else         req0_valid = 1'b0;
    end
    sccb_ready = 1'b0;
    repeat (5) tick();
    sccb_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (req0_done || req1_done) seen = 1'b1;
    end
    checks++;
    if ({req1_done, req0_done} !== (exp_gid ? 2'b10 : 2'b01)) begin
      errors++;
      $display("[TB] FAIL serve_done actual=%b required=%b", {req1_done, req0_done},
               exp_gid ? 2'b10 : 2'b01);
    end
    for (int k = 0; k < 40 && busy; k++) tick();
    checks++;
    if (busy !== 1'b0 || (n_err0 + n_err1) !== errs_before) begin
      errors++;
      $display("[TB] FAIL serve_idle actual busy=%0b errs=%0d required busy=0 errs=%0d",
               busy, n_err0 + n_err1, errs_before);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({req0_accept, req0_done, req0_err, req1_accept, req1_done, req1_err, sccb_start,
         sccb_addr, sccb_data, grant_id, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs actual=nonzero required=all zero");
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || sccb_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle actual busy=%0b start=%0b required 0/0", busy, sccb_start);
    end
  endtask

  task automatic test_single();
    n_acc0 = 0; n_done0 = 0; n_err0 = 0; n_start = 0;
    req0_addr = 8'h12; req0_data = 8'h80; req0_valid = 1'b1;
    tick();
    checks++;
    if ({req0_accept, sccb_start, grant_id, busy, sccb_addr, sccb_data} !== {4'b1101, 16'h1280}) begin
      errors++;
      $display("[TB] FAIL single_accept actual=%b_%h required=1101_1280",
               {req0_accept, sccb_start, grant_id, busy}, {sccb_addr, sccb_data});
    end
    req0_valid = 1'b0;
    tick();
    tick();
    sccb_ready = 1'b0;
    repeat (40) tick();
    sccb_ready = 1'b1;
    tick();
    checks++;
    if (req0_done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_done actual done=%0b busy=%0b required 1/1", req0_done, busy);
    end
    checks++;
    if (n_start !== 3) begin
      errors++;
      $display("[TB] FAIL single_start_len actual=%0d required=3", n_start);
    end
    repeat (15) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_gap_hold actual=%0b required=1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || {sccb_addr, sccb_data} !== 16'h1280) begin
      errors++;
      $display("[TB] FAIL single_gap_end actual busy=%0b ad=%h required busy=0 ad=1280",
               busy, {sccb_addr, sccb_data});
    end
    checks++;
    if (n_acc0 !== 1 || n_done0 !== 1 || n_err0 !== 0) begin
      errors++;
      $display("[TB] FAIL single_counts actual acc=%0d done=%0d err=%0d required 1/1/0",
               n_acc0, n_done0, n_err0);
    end
  endtask

  task automatic test_tie_after_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_addr = 8'hA0; req0_data = 8'h01; req1_addr = 8'hB0; req1_data = 8'h02;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(1'b1, 1'b0, 8'hA0, 8'h01);
    serve(1'b1, 1'b1, 8'hB0, 8'h02);
  endtask

  task automatic test_back_to_back();
    n_acc0 = 0; n_acc1 = 0;
    req0_addr = 8'h10; req0_data = 8'h11; req1_addr = 8'h20; req1_data = 8'h21;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(1'b0, 1'b0, 8'h10, 8'h11);
    serve(1'b0, 1'b1, 8'h20, 8'h21);
    serve(1'b0, 1'b0, 8'h10, 8'h11);
    serve(1'b0, 1'b1, 8'h20, 8'h21);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n_acc0 !== 2 || n_acc1 !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_accepts actual=%0d/%0d required=2/2", n_acc0, n_acc1);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    int d0;
    int e0;
    logic seen;
    d0 = n_done0; e0 = n_err0;
    sccb_ready = 1'b1;
    req0_addr = 8'h0A; req0_data = 8'h55; req0_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      if (sccb_start) seen = 1'b1;
    end
    req0_valid = 1'b0;
    cnt = seen ? 1 : 0;
    for (int k = 0; k < 400 && sccb_start; k++) begin
      tick();
      if (sccb_start) cnt++;
    end
    checks++;
    if (cnt !== 256) begin
      errors++;
      $display("[TB] FAIL timeout_start_len actual=%0d required=256", cnt);
    end
    checks++;
    if (req0_err !== 1'b1 || req0_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_err actual err=%0b done=%0b required 1/0", req0_err, req0_done);
    end
    for (int k = 0; k < 40 && busy; k++) tick();
    checks++;
    if (n_err0 - e0 !== 1 || n_done0 !== d0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_counts actual err=%0d done=%0d busy=%0b required 1/0/0",
               n_err0 - e0, n_done0 - d0, busy);
    end
    req0_addr = 8'h0B; req0_data = 8'h66; req0_valid = 1'b1;
    serve(1'b1, 1'b0, 8'h0B, 8'h66);
  endtask

  task automatic test_reset_mid_txn();
    int pulses;
    logic seen;
    req0_addr = 8'h77; req0_data = 8'h88; req0_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      if (sccb_start) seen = 1'b1;
    end
    req0_valid = 1'b0;
    sccb_ready = 1'b0;
    repeat (3) tick();
    req1_addr = 8'h33; req1_data = 8'h44; req1_valid = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || sccb_start !== 1'b0 || req1_accept !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_wait actual busy=%0b start=%0b acc1=%0b required 1/0/0",
               busy, sccb_start, req1_accept);
    end
    pulses = n_done0 + n_done1 + n_err0 + n_err1;
    rst = 1'b1;
    sccb_ready = 1'b1;
    tick();
    checks++;
    if ({req0_accept, req0_done, req0_err, req1_accept, req1_done, req1_err, sccb_start,
         sccb_addr, sccb_data, grant_id, busy} !== '0 ||
        (n_done0 + n_done1 + n_err0 + n_err1) !== pulses) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs actual start=%0b busy=%0b ad=%h required all zero",
               sccb_start, busy, {sccb_addr, sccb_data});
    end
    rst = 1'b0;
    serve(1'b1, 1'b1, 8'h33, 8'h44);
  endtask

  task automatic test_not_ready_and_nogap();
    int a1;
    logic seen;
    a1 = n_acc1;
    sccb_ready = 1'b0;
    req1_addr = 8'h21; req1_data = 8'h9A; req1_valid = 1'b1;
    repeat (6) tick();
    checks++;
    if (n_acc1 !== a1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL notready_hold actual acc=%0d busy=%0b required 0/0", n_acc1 - a1, busy);
    end
    sccb_ready = 1'b1;
    serve(1'b1, 1'b1, 8'h21, 8'h9A);

    b_req0_addr = 8'h01; b_req0_data = 8'h02; b_req0_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      if (b_sccb_start) seen = 1'b1;
    end
    b_req0_valid = 1'b0;
    b_sccb_ready = 1'b0;
    repeat (3) tick();
    b_sccb_ready = 1'b1;
    tick();
    checks++;
    if (b_req0_done !== 1'b1 || b_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nogap_done actual done=%0b busy=%0b required 1/0", b_req0_done, b_busy);
    end
    b_req1_addr = 8'h05; b_req1_data = 8'h06; b_req1_valid = 1'b1;
    tick();
    checks++;
    if ({b_req1_accept, b_sccb_start, b_grant_id, b_sccb_addr, b_sccb_data} !== {3'b111, 16'h0506}) begin
      errors++;
      $display("[TB] FAIL nogap_regrant actual=%b_%h required=111_0506",
               {b_req1_accept, b_sccb_start, b_grant_id}, {b_sccb_addr, b_sccb_data});
    end
    b_req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_after_reset();
    test_back_to_back();
    test_timeout();
    test_reset_mid_txn();
    test_not_ready_and_nogap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
